// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the four-digit BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int BCD_DIGITS = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int ACC_W = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic bcd_invalid(input logic [3:0] digit);
    return digit > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Start/ready handshake, digit inputs and result outputs of bcd2bin.
interface bcd2bin_if #(
  parameter int N = 16
);
  logic         strt_bin;
  logic [3:0]   bcd_ones;
  logic [3:0]   bcd_tens;
  logic [3:0]   bcd_hundreds;
  logic [3:0]   bcd_thousands;
  logic [N-1:0] out;
  logic         rdy;
  logic         busy;
  logic         err;

  modport master (
    output strt_bin, bcd_ones, bcd_tens, bcd_hundreds, bcd_thousands,
    input  out, rdy, busy, err
  );

  modport slave (
    input  strt_bin, bcd_ones, bcd_tens, bcd_hundreds, bcd_thousands,
    output out, rdy, busy, err
  );
endinterface

// File: rtl/bcd2bin_mul10_add.sv
// One Horner step: acc*10 + digit, built from shifts and adds, truncated to ACC_W.
module mul10_add
  import bcd2bin_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] result
);

  // All terms are ACC_W wide, so bits shifted past the top simply drop.
  assign result = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: four multiply-by-ten-and-add steps, thousands first.
//   state | meaning
//   IDLE  | waiting for strt_bin; latches digits and checks them on start
//   ACC   | one acc*10+digit step per cycle, idx counts 3 down to 0
//   DONE  | publishes out/err and pulses rdy, then back to IDLE
module bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter int N = 16
) (
  input  logic     clk,
  input  logic     rst,
  bcd2bin_if.slave bus
);

  state_t                         state, state_nxt;
  logic [1:0]                     idx;
  logic [BCD_DIGITS-1:0][3:0]     dig;
  logic                           err_flag;
  logic [ACC_W-1:0]               acc, acc_nxt;
  logic                           load, step, finish;
  logic                           any_invalid;

  assign any_invalid = bcd_invalid(bus.bcd_ones) | bcd_invalid(bus.bcd_tens) |
                       bcd_invalid(bus.bcd_hundreds) | bcd_invalid(bus.bcd_thousands);

  mul10_add u_mul10_add (
    .acc    (acc),
    .digit  (dig[idx]),
    .result (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.strt_bin) state_nxt = ACC;
      ACC:     if (idx == 2'd0)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load     = (state == IDLE) && bus.strt_bin;
    step     = (state == ACC);
    finish   = (state == DONE);
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= '0;
      idx      <= 2'd3;
      dig      <= '0;
      err_flag <= 1'b0;
      bus.out  <= '0;
      bus.rdy  <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      bus.rdy <= 1'b0;
      if (load) begin
        dig      <= {bus.bcd_thousands, bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones};
        err_flag <= any_invalid;
        acc      <= '0;
        idx      <= 2'd3;
      end
      if (step) begin
        acc <= acc_nxt;
        idx <= idx - 2'd1;
      end
      // Bad digits still run the full sequence so latency never varies.
      if (finish) begin
        bus.out <= err_flag ? '0 : N'(acc);
        bus.err <= err_flag;
        bus.rdy <= 1'b1;
      end
    end
  end

endmodule
